// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the flexible synchronous FIFO.
// Read-mode encodings plus a constant function used to size counters and pointers.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2, never less than 1 so a width is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_flex_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flex_ram.sv
// FIFO storage: DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge, read is combinational from the address.
// Backpressure: none; the caller only asserts we for accepted writes.
module sync_fifo_flex_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO with any depth >= 2, optional first-word fall-through and sticky error flags.
// Latency: standard mode data_out one cycle after an accepted read; FWFT shows the head word combinationally.
// Backpressure: writes while full are dropped unless a read is accepted the same cycle; reads while empty are dropped.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 8,
  parameter int FWFT          = FIFO_MODE_STD,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_flex_if.slave fifo
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AEMPTY_THRESH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  full;
  logic                  empty;
  logic                  rd_acc;
  logic                  wr_acc;

  // Non-power-of-two depths need an explicit wrap, not natural rollover.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count_q == CNT_FULL);
  assign empty  = (count_q == '0);
  assign rd_acc = fifo.rd_en && !empty;
  assign wr_acc = fifo.wr_en && (!full || rd_acc);

  sync_fifo_flex_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (fifo.data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (rd_acc) rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (FWFT == FIFO_MODE_STD && rd_acc) dout_q <= ram_rdata;
      if (fifo.wr_en && !wr_acc) overflow_q  <= 1'b1;
      if (fifo.rd_en && !rd_acc) underflow_q <= 1'b1;
    end
  end

  assign fifo.data_out     = (FWFT == FIFO_MODE_FWFT) ? ram_rdata : dout_q;
  assign fifo.full         = full;
  assign fifo.empty        = empty;
  assign fifo.almost_full  = (count_q >= CNT_AF);
  assign fifo.almost_empty = (count_q <= CNT_AE);
  assign fifo.count        = count_q;
  assign fifo.overflow     = overflow_q;
  assign fifo.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: a standard-mode and an FWFT instance (DEPTH=6, AF=5, AE=1) driven with directed vectors.
module tb_sync_fifo_flex;

  logic clk;
  logic rst_s;
  logic rst_f;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic       exp_s_vld = 1'b0;
  logic       exp_f_vld = 1'b0;

  sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(6)) if_s ();
  sync_fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(6)) if_f ();

  sync_fifo_flex #(
    .DATA_WIDTH(8), .DEPTH(6), .FWFT(0), .AFULL_THRESH(5), .AEMPTY_THRESH(1)
  ) dut_std (
    .clk  (clk),
    .rst  (rst_s),
    .fifo (if_s)
  );

  sync_fifo_flex #(
    .DATA_WIDTH(8), .DEPTH(6), .FWFT(1), .AFULL_THRESH(5), .AEMPTY_THRESH(1)
  ) dut_fwft (
    .clk  (clk),
    .rst  (rst_f),
    .fifo (if_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected occupancy flags follow from a hand-tracked count.
  task automatic flags_s(input string nm, input int cnt);
    chk({nm, "_count"}, int'(if_s.count), cnt);
    chk({nm, "_empty"}, int'(if_s.empty), int'(cnt == 0));
    chk({nm, "_full"},  int'(if_s.full),  int'(cnt == 6));
    chk({nm, "_afull"}, int'(if_s.almost_full),  int'(cnt >= 5));
    chk({nm, "_aempty"}, int'(if_s.almost_empty), int'(cnt <= 1));
  endtask

  task automatic step_s(input logic wr, input logic [7:0] d, input logic rd,
                        input logic ev, input logic [7:0] ed);
    if_s.wr_en   = wr;
    if_s.data_in = d;
    if_s.rd_en   = rd;
    exp_s_vld    = ev;
    if (ev) q_s.push_back(ed);
    @(posedge clk);
    #1;
    if_s.wr_en = 1'b0;
    if_s.rd_en = 1'b0;
    exp_s_vld  = 1'b0;
  endtask

  task automatic step_f(input logic wr, input logic [7:0] d, input logic rd,
                        input logic ev, input logic [7:0] ed);
    if_f.wr_en   = wr;
    if_f.data_in = d;
    if_f.rd_en   = rd;
    exp_f_vld    = ev;
    if (ev) q_f.push_back(ed);
    @(posedge clk);
    #1;
    if_f.wr_en = 1'b0;
    if_f.rd_en = 1'b0;
    exp_f_vld  = 1'b0;
  endtask

  task automatic reset_s();
    rst_s = 1'b1;
    step_s(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst_s = 1'b0;
  endtask

  // Standard mode: read data appears after the edge that accepted the read.
  initial begin : mon_s
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (exp_s_vld) begin
        @(negedge clk);
        if (q_s.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL std_sb_empty: read observed with no expected word");
        end else begin
          e = q_s.pop_front();
          chk("std_rd_data", int'(if_s.data_out), int'(e));
        end
      end
    end
  end

  // FWFT mode: the head word is on data_out during the cycle it is popped.
  initial begin : mon_f
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (exp_f_vld) begin
        if (q_f.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fwft_sb_empty: read observed with no expected word");
        end else begin
          e = q_f.pop_front();
          chk("fwft_rd_data", int'(if_f.data_out), int'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    if_s.wr_en = 1'b0; if_s.rd_en = 1'b0; if_s.data_in = 8'h00;
    if_f.wr_en = 1'b0; if_f.rd_en = 1'b0; if_f.data_in = 8'h00;
    rst_s = 1'b1;
    rst_f = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_s = 1'b0;
    rst_f = 1'b0;

    flags_s("rst", 0);
    chk("rst_overflow",  int'(if_s.overflow), 0);
    chk("rst_underflow", int'(if_s.underflow), 0);
    chk("rst_data_out",  int'(if_s.data_out), 0);
    chk("rst_fwft_empty", int'(if_f.empty), 1);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 6; i++) begin
      step_s(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 8'h00);
      flags_s("fill", i + 1);
    end
    step_s(1'b1, 8'h77, 1'b0, 1'b0, 8'h00);
    flags_s("ovf", 6);
    chk("ovf_set", int'(if_s.overflow), 1);

    // Drain; the rejected 0x77 must never appear.
    for (int i = 0; i < 6; i++) begin
      step_s(1'b0, 8'h00, 1'b1, 1'b1, 8'h11 + 8'(i));
      flags_s("drain", 5 - i);
    end
    step_s(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    flags_s("unf", 0);
    chk("unf_set", int'(if_s.underflow), 1);
    chk("unf_hold_data", int'(if_s.data_out), 8'h16);
    chk("ovf_sticky", int'(if_s.overflow), 1);

    reset_s();
    chk("clr_overflow",  int'(if_s.overflow), 0);
    chk("clr_underflow", int'(if_s.underflow), 0);

    // Wrap-around at steady count 3.
    for (int i = 0; i < 3; i++) step_s(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step_s(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b1, (i < 3) ? 8'hB0 + 8'(i) : 8'hA0 + 8'(i - 3));
      chk("wrap_count", int'(if_s.count), 3);
    end
    for (int i = 0; i < 3; i++) step_s(1'b0, 8'h00, 1'b1, 1'b1, 8'hA7 + 8'(i));
    flags_s("wrap_end", 0);

    // Full with simultaneous write and read.
    for (int i = 0; i < 6; i++) step_s(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 8'h00);
    step_s(1'b1, 8'hC6, 1'b1, 1'b1, 8'hC0);
    flags_s("full_both", 6);
    chk("full_both_ovf", int'(if_s.overflow), 0);
    for (int i = 0; i < 6; i++) step_s(1'b0, 8'h00, 1'b1, 1'b1, 8'hC1 + 8'(i));
    flags_s("full_both_drain", 0);

    // Empty with simultaneous write and read: write only.
    step_s(1'b1, 8'hD0, 1'b1, 1'b0, 8'h00);
    flags_s("empty_both", 1);
    chk("empty_both_unf", int'(if_s.underflow), 1);
    step_s(1'b0, 8'h00, 1'b1, 1'b1, 8'hD0);
    flags_s("empty_both_drain", 0);

    // Mid-operation reset wins over a concurrent write.
    reset_s();
    for (int i = 0; i < 4; i++) step_s(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0, 8'h00);
    flags_s("pre_rst", 4);
    rst_s = 1'b1;
    step_s(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
    rst_s = 1'b0;
    flags_s("mid_rst", 0);
    chk("mid_rst_ovf", int'(if_s.overflow), 0);
    chk("mid_rst_unf", int'(if_s.underflow), 0);
    chk("mid_rst_data", int'(if_s.data_out), 0);
    step_s(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
    step_s(1'b0, 8'h00, 1'b1, 1'b1, 8'h3C);
    step_s(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    flags_s("post_rst", 0);

    // FWFT: written word visible right after its edge.
    step_f(1'b1, 8'h5A, 1'b0, 1'b0, 8'h00);
    chk("fwft_empty_after_wr", int'(if_f.empty), 0);
    chk("fwft_data_after_wr", int'(if_f.data_out), 8'h5A);
    chk("fwft_count_after_wr", int'(if_f.count), 1);
    step_f(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A);
    chk("fwft_empty_after_pop", int'(if_f.empty), 1);
    chk("fwft_count_after_pop", int'(if_f.count), 0);
    step_f(1'b1, 8'h61, 1'b0, 1'b0, 8'h00);
    step_f(1'b1, 8'h62, 1'b1, 1'b1, 8'h61);
    chk("fwft_next_head", int'(if_f.data_out), 8'h62);
    chk("fwft_count_both", int'(if_f.count), 1);
    step_f(1'b0, 8'h00, 1'b1, 1'b1, 8'h62);
    chk("fwft_final_empty", int'(if_f.empty), 1);
    step_f(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("fwft_underflow", int'(if_f.underflow), 1);

    repeat (2) @(posedge clk);
    #1;
    chk("std_sb_drained",  q_s.size(), 0);
    chk("fwft_sb_drained", q_f.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
